// File: rtl/multdiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, decode
// fields and the $rstatus exception codes shared with the control decoder.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WB   = 2'b10
    } md_state_t;

    localparam logic [4:0] OPCODE_RTYPE = 5'b00000;
    localparam logic [4:0] ALUOP_MUL    = 5'b00110;
    localparam logic [4:0] ALUOP_DIV    = 5'b00111;

    localparam int unsigned RSTATUS_REG = 30;

    // $rstatus codes; 1..3 are the add/addi/sub overflow codes from the decoder
    localparam int unsigned ADD_OVF_EXC  = 1;
    localparam int unsigned ADDI_OVF_EXC = 2;
    localparam int unsigned SUB_OVF_EXC  = 3;
    localparam int unsigned MUL_EXC      = 4;
    localparam int unsigned DIV_EXC      = 5;

endpackage

// File: rtl/multdiv_sequencer_md_timeout_counter.sv
// Saturating BUSY-cycle counter; terminal is high while count == TIMEOUT_CYCLES-1.
// Clear has priority over enable; no backpressure.
module md_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues mul/div to the iterative unit, stalls until result/exception/timeout,
// then one writeback cycle; start pulse is 1 cycle after issue, stall is combinational.
module multdiv_sequencer #(
    parameter int          TIMEOUT_CYCLES = 40,
    parameter int          CNT_W          = 6,
    parameter int unsigned RSTATUS_REG    = multdiv_sequencer_pkg::RSTATUS_REG,
    parameter int unsigned MUL_EXC        = multdiv_sequencer_pkg::MUL_EXC,
    parameter int unsigned DIV_EXC        = multdiv_sequencer_pkg::DIV_EXC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [4:0]  opcode,
    input  logic [4:0]  ALUop,
    input  logic [4:0]  rd,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy
);

    import multdiv_sequencer_pkg::*;

    md_state_t   state_q;
    md_state_t   state_d;
    logic        start_req;
    logic        start_div;
    logic        launch;
    logic        cnt_clear;
    logic        cnt_en;
    logic        cnt_term;
    logic [4:0]  rd_q;
    logic        is_div_q;
    logic        exc_q;
    logic [31:0] result_q;

    assign start_div = (ALUop == ALUOP_DIV);
    assign start_req = instr_valid && (opcode == OPCODE_RTYPE)
                       && ((ALUop == ALUOP_MUL) || start_div);

    md_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (cnt_term)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        launch    = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        wb_we     = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        case (state_q)
            IDLE: begin
                // Combinational so the issuing instruction is frozen in decode this cycle.
                stall = start_req;
                if (start_req) begin
                    launch    = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                if (md_ready || cnt_term) begin
                    state_d = WB;
                end
            end
            WB: begin
                stall   = 1'b1;
                state_d = IDLE;
                if (exc_q) begin
                    wb_we   = 1'b1;
                    wb_reg  = 5'(RSTATUS_REG);
                    wb_data = is_div_q ? 32'(DIV_EXC) : 32'(MUL_EXC);
                end else begin
                    wb_we   = (rd_q != 5'd0);
                    wb_reg  = rd_q;
                    wb_data = result_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            rd_q      <= '0;
            is_div_q  <= 1'b0;
            exc_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            ctrl_MULT <= launch && !start_div;
            ctrl_DIV  <= launch && start_div;
            if (launch) begin
                rd_q     <= rd;
                is_div_q <= start_div;
                exc_q    <= 1'b0;
                result_q <= '0;
            end
            // A unit result in the timeout cycle still takes precedence.
            if (state_q == BUSY) begin
                if (md_ready) begin
                    result_q <= md_result;
                    exc_q    <= md_exception;
                end else if (cnt_term) begin
                    result_q <= '0;
                    exc_q    <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: expected register writes are queued at
// issue and popped when the DUT raises wb_we; per-op stall and pulse counts are checked.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [4:0]  opcode;
    logic [4:0]  ALUop;
    logic [4:0]  rd;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];

    int nchecks = 0;
    int nerr    = 0;
    int stall_cnt, mult_cnt, div_cnt, write_cnt;

    logic        s_stall, s_mult, s_div, s_we, s_busy;
    logic [4:0]  s_reg;
    logic [31:0] s_data;

    multdiv_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .ALUop        (ALUop),
        .rd           (rd),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .md_result    (md_result),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .stall        (stall),
        .wb_we        (wb_we),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        stall_cnt = 0;
        mult_cnt  = 0;
        div_cnt   = 0;
        write_cnt = 0;
    endtask

    task automatic idle_inputs();
        instr_valid  = 1'b0;
        opcode       = 5'b00000;
        ALUop        = 5'b00000;
        rd           = 5'd0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'h0;
    endtask

    task automatic set_instr(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] dst);
        instr_valid = 1'b1;
        opcode      = op;
        ALUop       = alu;
        rd          = dst;
    endtask

    // One clock: sample at negedge, score any write, then step past the posedge.
    task automatic cycle();
        wr_t e;
        @(negedge clock);
        s_stall = stall;
        s_mult  = ctrl_MULT;
        s_div   = ctrl_DIV;
        s_we    = wb_we;
        s_busy  = busy;
        s_reg   = wb_reg;
        s_data  = wb_data;
        if (s_stall) stall_cnt++;
        if (s_mult)  mult_cnt++;
        if (s_div)   div_cnt++;
        if (s_we === 1'b1) begin
            write_cnt++;
            nchecks++;
            assert (sb.size() != 0) else begin
                nerr++;
                $error("FAIL unexpected_write: observed reg %0d data 0x%0h expected no write", s_reg, s_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wb_reg", 32'(s_reg), 32'(e.r));
                check("wb_data", s_data, e.d);
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Issue, n_busy BUSY cycles (md_ready on the last one if give_ready), WB, one IDLE.
    task automatic run_op(input bit is_div, input logic [4:0] dst, input int n_busy,
                          input bit give_ready, input bit exc_v, input logic [31:0] res_v);
        clear_counts();
        set_instr(5'b00000, is_div ? 5'b00111 : 5'b00110, dst);
        cycle();
        check("issue_stall", 32'(s_stall), 32'd1);
        check("issue_no_pulse", 32'({s_mult, s_div}), 32'd0);
        idle_inputs();
        for (int i = 1; i <= n_busy; i++) begin
            if (give_ready && i == n_busy) begin
                md_ready     = 1'b1;
                md_exception = exc_v;
                md_result    = res_v;
            end
            cycle();
            if (i == 1) begin
                check("start_pulse", 32'({s_mult, s_div}), is_div ? 32'd1 : 32'd2);
                check("busy_run", 32'(s_busy), 32'd1);
            end
            md_ready     = 1'b0;
            md_exception = 1'b0;
            md_result    = 32'h0;
        end
        cycle();
        check("wb_busy", 32'(s_busy), 32'd1);
        cycle();
        check("post_stall", 32'(s_stall), 32'd0);
        check("post_busy", 32'(s_busy), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        clear_counts();
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_stall", 32'(s_stall), 32'd0);
        check("rst_pulses", 32'({s_mult, s_div}), 32'd0);
        check("rst_we", 32'(s_we), 32'd0);
        check("rst_reg", 32'(s_reg), 32'd0);
        check("rst_data", s_data, 32'd0);

        // mul rd=5, result after 32 BUSY cycles
        sb.push_back('{r: 5'd5, d: 32'h0000_00C8});
        run_op(1'b0, 5'd5, 32, 1'b1, 1'b0, 32'h0000_00C8);
        check("mul_stall_len", 32'(stall_cnt), 32'd34);
        check("mul_pulses", 32'(mult_cnt), 32'd1);
        check("mul_no_div", 32'(div_cnt), 32'd0);
        check("mul_writes", 32'(write_cnt), 32'd1);

        // div rd=7 divide by zero -> $rstatus = 5
        sb.push_back('{r: 5'd30, d: 32'd5});
        run_op(1'b1, 5'd7, 6, 1'b1, 1'b1, 32'hFFFF_FFFF);
        check("divz_stall_len", 32'(stall_cnt), 32'd8);
        check("divz_pulses", 32'(div_cnt), 32'd1);
        check("divz_writes", 32'(write_cnt), 32'd1);

        // mul that never completes: timeout after 40 BUSY cycles -> $rstatus = 4
        sb.push_back('{r: 5'd30, d: 32'd4});
        run_op(1'b0, 5'd9, 40, 1'b0, 1'b0, 32'h0);
        check("tmo_stall_len", 32'(stall_cnt), 32'd42);
        check("tmo_writes", 32'(write_cnt), 32'd1);
        clear_counts();
        md_ready  = 1'b1;
        md_result = 32'hDEAD_BEEF;
        cycle();
        idle_inputs();
        cycle();
        check("late_ready_writes", 32'(write_cnt), 32'd0);
        check("late_ready_busy", 32'(s_busy), 32'd0);

        // mul rd=0: no register write but normal stall shape
        run_op(1'b0, 5'd0, 4, 1'b1, 1'b0, 32'h0000_1234);
        check("rd0_writes", 32'(write_cnt), 32'd0);
        check("rd0_stall_len", 32'(stall_cnt), 32'd6);

        // reset during BUSY cycle 10
        clear_counts();
        set_instr(5'b00000, 5'b00111, 5'd3);
        cycle();
        idle_inputs();
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) reset = 1'b1;
            cycle();
        end
        reset     = 1'b0;
        md_ready  = 1'b1;
        md_result = 32'h0000_0077;
        cycle();
        check("rstmid_busy", 32'(s_busy), 32'd0);
        check("rstmid_stall", 32'(s_stall), 32'd0);
        check("rstmid_we", 32'(s_we), 32'd0);
        idle_inputs();
        cycle();
        check("rstmid_pulses", 32'(div_cnt + mult_cnt), 32'd1);
        check("rstmid_writes", 32'(write_cnt), 32'd0);

        sb.push_back('{r: 5'd7, d: 32'h0000_0003});
        run_op(1'b1, 5'd7, 3, 1'b1, 1'b0, 32'h0000_0003);
        check("div_after_rst_writes", 32'(write_cnt), 32'd1);
        check("div_after_rst_stall", 32'(stall_cnt), 32'd5);

        // back-to-back: div presented while mul runs, held by stall
        clear_counts();
        sb.push_back('{r: 5'd4, d: 32'h0000_0011});
        sb.push_back('{r: 5'd6, d: 32'h0000_0022});
        set_instr(5'b00000, 5'b00110, 5'd4);
        cycle();
        set_instr(5'b00000, 5'b00111, 5'd6);
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin
                md_ready  = 1'b1;
                md_result = 32'h0000_0011;
            end
            cycle();
            md_ready  = 1'b0;
            md_result = 32'h0;
        end
        cycle();
        check("b2b_wb1_no_div", 32'(div_cnt), 32'd0);
        cycle();
        check("b2b_issue2_stall", 32'(s_stall), 32'd1);
        check("b2b_issue2_idle", 32'(s_busy), 32'd0);
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                md_ready  = 1'b1;
                md_result = 32'h0000_0022;
            end
            cycle();
            if (i == 1) check("b2b_div_pulse", 32'(s_div), 32'd1);
            md_ready  = 1'b0;
            md_result = 32'h0;
        end
        cycle();
        cycle();
        check("b2b_post_stall", 32'(s_stall), 32'd0);
        check("b2b_stall_len", 32'(stall_cnt), 32'd11);
        check("b2b_pulses", 32'({mult_cnt[3:0], div_cnt[3:0]}), 32'h11);
        check("b2b_writes", 32'(write_cnt), 32'd2);

        // non-mul/div instructions never stall or start the unit
        clear_counts();
        set_instr(5'b00000, 5'b00000, 5'd2);
        cycle();
        check("add_stall", 32'(s_stall), 32'd0);
        set_instr(5'b01000, 5'b00110, 5'd2);
        cycle();
        check("lw_stall", 32'(s_stall), 32'd0);
        set_instr(5'b00000, 5'b00110, 5'd2);
        instr_valid = 1'b0;
        cycle();
        check("invalid_stall", 32'(s_stall), 32'd0);
        idle_inputs();
        cycle();
        cycle();
        check("other_pulses", 32'(mult_cnt + div_cnt), 32'd0);
        check("other_busy", 32'(s_busy), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
